// File: rtl/tc_array.sv
// tc_array: NUM_CH independent 32-bit timer/counter channels behind one
// word-addressed register window with byte-enabled writes and W1C status.
module tc_array #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Addr,
   input  logic              WE,
   input  logic [3:0]        byteen,
   input  logic [31:0]       Din,
   output logic [31:0]       Dout,
   output logic [NUM_CH-1:0] IRQ,
   output logic              IRQ_any
);
   typedef enum logic {IDLE, CNT} state_t;

   localparam logic [ADDR_W-1:0] GLOBAL_ADDR = ADDR_W'(4 * NUM_CH);

   logic [3:0]        ctrl_q   [NUM_CH];
   logic [31:0]       preset_q [NUM_CH];
   logic [31:0]       count_q  [NUM_CH];
   logic [NUM_CH-1:0] pending;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(4 * i);
      localparam logic [ADDR_W-1:0] A_PRESET = ADDR_W'(4 * i + 1);
      localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4 * i + 3);

      state_t      state, state_nxt;
      logic [3:0]  ctrl;
      logic [31:0] preset, count, count_nxt;
      logic        pend, fire, en_clr;
      logic        wr_ctrl, wr_preset, clr_status;

      assign wr_ctrl    = WE && (Addr == A_CTRL) && byteen[0];
      assign wr_preset  = WE && (Addr == A_PRESET);
      assign clr_status = WE && (Addr == A_STATUS) && byteen[0] && Din[0];

      always_comb begin
         state_nxt = state;
         count_nxt = count;
         fire      = 1'b0;
         en_clr    = 1'b0;
         case (state)
            IDLE: begin
               if (ctrl[0]) begin
                  count_nxt = preset;
                  state_nxt = CNT;
               end
            end
            CNT: begin
               if (!ctrl[0]) begin
                  state_nxt = IDLE;
               end else if (ctrl[2:1] == 2'b10) begin
                  count_nxt = count + 32'd1;
                  fire      = (count == 32'hFFFF_FFFF);
               end else if (count != 32'd0) begin
                  count_nxt = count - 32'd1;
               end else begin
                  fire = 1'b1;
                  if (ctrl[2:1] == 2'b01) begin
                     count_nxt = preset;
                  end else begin
                     en_clr    = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state <= IDLE;
            count <= '0;
         end else begin
            state <= state_nxt;
            count <= count_nxt;
         end
      end

      // Software CTRL writes override the one-shot EN clear; a hardware fire overrides W1C.
      always_ff @(posedge clk) begin
         if (reset) begin
            ctrl   <= '0;
            preset <= '0;
            pend   <= 1'b0;
         end else begin
            if (wr_ctrl) begin
               ctrl <= Din[3:0];
            end else if (en_clr) begin
               ctrl[0] <= 1'b0;
            end
            if (wr_preset) preset <= merge_bytes(preset, Din, byteen);
            if (fire) begin
               pend <= 1'b1;
            end else if (clr_status) begin
               pend <= 1'b0;
            end
         end
      end

      assign ctrl_q[i]   = ctrl;
      assign preset_q[i] = preset;
      assign count_q[i]  = count;
      assign pending[i]  = pend;
      assign IRQ[i]      = pend & ctrl[3];
   end

   assign IRQ_any = |IRQ;

   always_comb begin
      Dout = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (Addr == ADDR_W'(4 * i))     Dout = {28'd0, ctrl_q[i]};
         if (Addr == ADDR_W'(4 * i + 1)) Dout = preset_q[i];
         if (Addr == ADDR_W'(4 * i + 2)) Dout = count_q[i];
         if (Addr == ADDR_W'(4 * i + 3)) Dout = {31'd0, pending[i]};
      end
      if (Addr == GLOBAL_ADDR) Dout = 32'(pending);
   end
endmodule

// File: tb/tb_tc_array.sv
// Self-checking bench for tc_array: directed register/corner sequences plus
// randomized bus traffic compared against a behavioural channel model.
module tb_tc_array;
   localparam int NUM_CH = 2;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] Addr;
   logic              WE;
   logic [3:0]        byteen;
   logic [31:0]       Din;
   logic [31:0]       Dout;
   logic [NUM_CH-1:0] IRQ;
   logic              IRQ_any;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tc_array #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .byteen(byteen),
      .Din(Din), .Dout(Dout), .IRQ(IRQ), .IRQ_any(IRQ_any)
   );

   // Model state: what software would see in each channel's registers.
   bit        m_en   [NUM_CH];
   bit [1:0]  m_mode [NUM_CH];
   bit        m_im   [NUM_CH];
   bit [31:0] m_preset [NUM_CH];
   bit [31:0] m_count  [NUM_CH];
   bit        m_pend [NUM_CH];
   bit        m_run  [NUM_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input int a);
      int c;
      logic [31:0] v;
      v = '0;
      if (a < 4 * NUM_CH) begin
         c = a / 4;
         case (a % 4)
            0: v = {28'd0, m_im[c], m_mode[c], m_en[c]};
            1: v = m_preset[c];
            2: v = m_count[c];
            default: v = {31'd0, m_pend[c]};
         endcase
      end else if (a == 4 * NUM_CH) begin
         for (int k = 0; k < NUM_CH; k++) v[k] = m_pend[k];
      end
      return v;
   endfunction

   // One clock edge of the peripheral as described by its counting rules.
   task automatic model_step();
      bit fire, en_clr;
      int a;
      a = int'(Addr);
      for (int c = 0; c < NUM_CH; c++) begin
         if (reset) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_preset[c] = 0;
            m_count[c] = 0; m_pend[c] = 0; m_run[c] = 0;
            continue;
         end
         fire = 0;
         en_clr = 0;
         if (!m_run[c]) begin
            if (m_en[c]) begin
               m_count[c] = m_preset[c];
               m_run[c] = 1;
            end
         end else if (!m_en[c]) begin
            m_run[c] = 0;
         end else if (m_mode[c] == 2) begin
            fire = (m_count[c] == 32'hFFFF_FFFF);
            m_count[c] = m_count[c] + 1;
         end else if (m_count[c] != 0) begin
            m_count[c] = m_count[c] - 1;
         end else begin
            fire = 1;
            if (m_mode[c] == 1) m_count[c] = m_preset[c];
            else begin
               en_clr = 1;
               m_run[c] = 0;
            end
         end
         if (en_clr) m_en[c] = 0;
         if (WE) begin
            if (a == 4 * c && byteen[0]) begin
               m_en[c] = Din[0];
               m_mode[c] = Din[2:1];
               m_im[c] = Din[3];
            end
            if (a == 4 * c + 1)
               for (int b = 0; b < 4; b++)
                  if (byteen[b]) m_preset[c][8*b +: 8] = Din[8*b +: 8];
            if (a == 4 * c + 3 && byteen[0] && Din[0]) m_pend[c] = 0;
         end
         if (fire) m_pend[c] = 1;
      end
   endtask

   task automatic checkOutput();
      logic [NUM_CH-1:0] exp_irq;
      for (int c = 0; c < NUM_CH; c++) exp_irq[c] = m_pend[c] & m_im[c];
      check("irq", 32'(IRQ), 32'(exp_irq));
      check("irq_any", 32'(IRQ_any), 32'(|exp_irq));
      check($sformatf("dout@%0d", Addr), Dout, model_read(int'(Addr)));
   endtask

   task automatic applyStimulus(input bit we, input int addr, input logic [3:0] be,
                                input logic [31:0] din);
      WE = we;
      Addr = ADDR_W'(addr);
      byteen = be;
      Din = din;
      @(posedge clk);
      model_step();
      #1;
      checkOutput();
      WE = 1'b0;
   endtask

   task automatic wait_irq(input int ch, input int addr, output int k);
      k = 0;
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(0, addr, 4'h0, 32'h0);
         if (IRQ[ch]) begin
            k = n;
            break;
         end
      end
      if (k == 0) k = 99;
   endtask

   typedef struct {
      bit          we;
      int          addr;
      logic [3:0]  be;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int k;
      reset = 1'b1; WE = 1'b0; Addr = '0; byteen = '0; Din = '0;
      vecs.delete();
      for (int a = 0; a <= 4 * NUM_CH; a++) vecs.push_back('{0, a, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{1, 1, 4'hF, 32'h1122_3344, 32'h1122_3344});
      vecs.push_back('{1, 1, 4'b0010, 32'h0000_AB00, 32'h1122_AB44});
      vecs.push_back('{1, 2, 4'hF, 32'hDEAD_BEEF, 32'h0});
      vecs.push_back('{1, 4 * NUM_CH + 1, 4'hF, 32'hFFFF_FFFF, 32'h0});
      vecs.push_back('{0, 4 * NUM_CH + 1, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{0, 1, 4'h0, 32'h0, 32'h1122_AB44});
      vecs.push_back('{1, 0, 4'hF, 32'hFFFF_FFF0, 32'h0});
      vecs.push_back('{1, 4, 4'b1110, 32'h0000_000F, 32'h0});
      vecs.push_back('{1, 4 * NUM_CH, 4'hF, 32'hFFFF_FFFF, 32'h0});

      applyStimulus(0, 0, 4'h0, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0);
      reset = 1'b0;
      check("reset_irq", 32'(IRQ), 32'h0);
      check("reset_irq_any", 32'(IRQ_any), 32'h0);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].din);
         check($sformatf("vec%0d", i), Dout, vecs[i].exp);
      end

      // One-shot on ch0.
      applyStimulus(1, 1, 4'hF, 32'd5);
      applyStimulus(1, 0, 4'hF, 32'h9);
      wait_irq(0, 2, k);
      check("oneshot_latency", 32'(k), 32'd7);
      check("oneshot_count", Dout, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0);
      check("oneshot_ctrl", Dout, 32'h8);
      applyStimulus(1, 3, 4'h1, 32'h1);
      check("oneshot_w1c", 32'(IRQ[0]), 32'h0);

      // Periodic on ch1.
      applyStimulus(1, 5, 4'hF, 32'd3);
      applyStimulus(1, 4, 4'hF, 32'hB);
      wait_irq(1, 6, k);
      check("periodic_first", 32'(k), 32'd5);
      check("periodic_reload", Dout, 32'd3);
      applyStimulus(1, 7, 4'h1, 32'h1);
      check("periodic_w1c", 32'(IRQ[1]), 32'h0);
      wait_irq(1, 6, k);
      check("periodic_period", 32'(k), 32'd3);
      applyStimulus(1, 7, 4'h1, 32'h1);
      applyStimulus(0, 6, 4'h0, 32'h0);
      applyStimulus(0, 6, 4'h0, 32'h0);
      applyStimulus(1, 7, 4'h1, 32'h1);
      check("w1c_collision", 32'(IRQ[1]), 32'h1);
      applyStimulus(1, 4, 4'hF, 32'h0);
      applyStimulus(1, 7, 4'h1, 32'h1);

      // Free-run wrap on ch0 with interrupt masked.
      applyStimulus(1, 1, 4'hF, 32'hFFFF_FFFE);
      applyStimulus(1, 0, 4'hF, 32'h5);
      applyStimulus(0, 2, 4'h0, 32'h0);
      check("free_load", Dout, 32'hFFFF_FFFE);
      applyStimulus(0, 2, 4'h0, 32'h0);
      check("free_max", Dout, 32'hFFFF_FFFF);
      applyStimulus(0, 2, 4'h0, 32'h0);
      check("free_wrap", Dout, 32'h0);
      applyStimulus(0, 4 * NUM_CH, 4'h0, 32'h0);
      check("free_global", Dout, 32'h1);
      check("free_masked", 32'(IRQ[0]), 32'h0);
      applyStimulus(1, 0, 4'h1, 32'hD);
      check("free_unmask", 32'(IRQ[0]), 32'h1);
      applyStimulus(1, 0, 4'h1, 32'h0);
      applyStimulus(1, 3, 4'h1, 32'h1);

      // Reset in the middle of counting.
      applyStimulus(1, 1, 4'hF, 32'd100);
      applyStimulus(1, 5, 4'hF, 32'd0);
      applyStimulus(1, 0, 4'hF, 32'h9);
      applyStimulus(1, 4, 4'hF, 32'h9);
      applyStimulus(0, 2, 4'h0, 32'h0);
      applyStimulus(0, 2, 4'h0, 32'h0);
      check("pre_reset_any", 32'(IRQ_any), 32'h1);
      reset = 1'b1;
      applyStimulus(1, 1, 4'hF, 32'd55);
      reset = 1'b0;
      check("post_reset_any", 32'(IRQ_any), 32'h0);
      for (int a = 0; a <= 4 * NUM_CH; a++) begin
         applyStimulus(0, a, 4'h0, 32'h0);
         check($sformatf("post_reset_rd%0d", a), Dout, 32'h0);
      end

      // ch1 fires masked, ch0 fires unmasked: IRQ_any follows ch0 only.
      applyStimulus(1, 5, 4'hF, 32'd1);
      applyStimulus(1, 4, 4'hF, 32'h3);
      applyStimulus(1, 1, 4'hF, 32'd2);
      applyStimulus(1, 0, 4'hF, 32'h9);
      for (int n = 1; n <= 6; n++) begin
         applyStimulus(0, 4 * NUM_CH, 4'h0, 32'h0);
         check($sformatf("any_follows_ch0_%0d", n), 32'(IRQ_any), (n >= 4) ? 32'h1 : 32'h0);
      end
      check("global_both", Dout, 32'h3);

      // Randomized bus traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4 * NUM_CH + 1)),
                       4'($urandom), ($urandom_range(0, 3) == 0) ? $urandom
                                                              : 32'($urandom_range(0, 15)));
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tc_array.md
# tc_array

Parametrised multi-channel timer/counter peripheral; the successor to the two-instance fixed timer used beside the CPU bridge. Provides NUM_CH independent 32-bit channels behind one word-addressed register window, with byte-enabled writes, three counting modes, per-channel interrupt mask and write-1-to-clear pending flags. Per-channel IRQs and an OR-reduced IRQ_any feed the CPU hardware-interrupt vector.

## Interface
- NUM_CH, 2, channel count, 1..8
- ADDR_W, 6, word-address width; 4*NUM_CH+1 <= 2**ADDR_W required
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- Addr  in  ADDR_W  word address within block (byte address bits [ADDR_W+1:2])
- WE  in  1  write strobe, sampled at clk edge
- byteen  in  4  byte enables for write; byte k = Din[8k+7:8k]
- Din  in  32  write data
- Dout  out  32  read data, combinational from Addr
- IRQ  out  NUM_CH  per-channel interrupt, pending & IM
- IRQ_any  out  1  OR of IRQ

## Operation
- Register map, channel i at word 4i: +0 CTRL (RW), +1 PRESET (RW), +2 COUNT (RO), +3 STATUS (bit0 pending, W1C). Word 4*NUM_CH: GLOBAL (RO, bits [NUM_CH-1:0] = pending vector). All other words read 0, writes ignored.
- CTRL: [0] EN, [2:1] MODE, [3] IM; bits [31:4] read 0, write-ignored.
- MODE 00 one-shot, 01 periodic (auto-reload), 10 free-run up-count, 11 treated as 00.
- Writes to CTRL/PRESET merge per byteen; STATUS clear uses byteen[0] && Din[0]; writes to COUNT/GLOBAL ignored.
- Per-channel FSM, states IDLE, CNT:
  - IDLE: COUNT held. If EN=1: COUNT<=PRESET, ->CNT.
  - CNT, EN=0: ->IDLE, COUNT held.
  - CNT, MODE 00/11: COUNT!=0 -> COUNT-1; COUNT==0 -> pending<=1, EN<=0, ->IDLE.
  - CNT, MODE 01: COUNT!=0 -> COUNT-1; COUNT==0 -> pending<=1, COUNT<=PRESET, stay CNT.
  - CNT, MODE 10: COUNT<=COUNT+1 (mod 2^32); on 32'hFFFFFFFF->0 set pending.
- PRESET writes during CNT take effect at next load only. MODE change during CNT takes effect the following cycle; no reload.
- Collisions: software CTRL write wins over hardware EN clear in same cycle; hardware pending set wins over W1C in same cycle.
- IRQ[i] = pending[i] & IM[i]; masking does not clear pending.

## Timing
- Reset: CTRL, PRESET, COUNT, pending = 0, FSM IDLE, IRQ = 0, IRQ_any = 0. A write coincident with reset is discarded. Reset mid-count aborts immediately.
- Register write visible on Dout the cycle after the WE edge.
- Write EN=1 at edge E0, PRESET=N: COUNT=N after E1, reaches 0 after E(N+1), pending/IRQ set after E(N+2).
- Periodic: subsequent pending sets every N+1 cycles; PRESET=0 sets pending every cycle from E2.
- One-shot: CTRL.EN reads 0 after the firing edge; COUNT stays 0.
- IRQ and IRQ_any are registered-state combinational: same cycle as pending, no extra latency.
- Dout purely combinational; no read side effects.

## Test plan
- Reset then read every word 0..4*NUM_CH -> all 0; IRQ=0, IRQ_any=0.
- Ch0 PRESET=5, CTRL=4'b1001 (one-shot, IM) at E0 -> IRQ[0] rises after E7; CTRL reads 4'b1000; COUNT=0; STATUS write 1 -> IRQ[0] low next cycle.
- Ch1 PRESET=3, CTRL=4'b1011 (periodic) -> pending set after E5, COUNT reloads to 3; W1C each time -> re-set every 4 cycles; W1C on firing cycle leaves pending=1.
- Ch0 MODE 10, PRESET=32'hFFFFFFFE, IM=0 -> COUNT FFFFFFFF, 0; GLOBAL bit0=1 while IRQ[0]=0; set IM -> IRQ[0]=1.
- byteen=4'b0010, Din=32'h0000AB00 to PRESET=32'h11223344 -> 32'h1122AB44; write to COUNT and word 4*NUM_CH+1 -> no change, reads 0 for unmapped.
- Start both channels, assert reset mid-count -> all registers 0, IRQ_any=0 next cycle; ch0 firing while ch1 masked -> IRQ_any follows ch0 only.
